// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell and a carry flop, LSB first, start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` port that turns the operation into a - b.

module serial_adder_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_sh, b_sh, r_sh, r_next;
    logic [W-1:0]   b_cap;
    logic           c_cap;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           s, co, last;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign b_cap = sub ? ~b : b;
    assign c_cap = sub ? 1'b1 : cin;
`else
    assign b_cap = b;
    assign c_cap = cin;
`endif

    serial_adder_fa u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // New bit enters at the MSB so after W shifts bit 0 of the result sits at r_sh[0].
    generate
        if (W == 1) begin : g_r1
            assign r_next = s;
        end else begin : g_rn
            assign r_next = {s, r_sh[W-1:1]};
        end
    endgenerate

    assign last = (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_cap;
                        carry <= c_cap;
                        r_sh  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    carry <= co;
                    r_sh  <= r_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CW'(1);
                    // Outputs move only here, so partial results are never visible.
                    if (last) begin
                        sum  <= r_next;
                        cout <= co;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: one full-adder cell plus a carry flip-flop, processing one bit per clock, LSB first.
- The addition-direction counterpart to the team's combinational full subtractor.
- Area-cheap arithmetic for slow datapaths; operands accepted through a start/busy/done handshake.

Parameters:
- W, 8, operand and result width in bits; legal range W >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A; captured on the accepted start.
- b  input  W  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  W  registered result; holds its value until the next completion.
- cout  output  1  registered final carry.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry and bit counter cleared.
- Reset mid-operation aborts the operation with no done pulse; operation resumes only on a new start after release.
- States:
  - IDLE: on a clk edge with start=1, latch a->a_sh, b->b_sh, cin->carry; cnt=0; busy<=1; go to SHIFT.
  - SHIFT, each edge:
    - s = a_sh[0]^b_sh[0]^carry.
    - carry <= majority(a_sh[0], b_sh[0], carry).
    - Shift s into r_sh from the MSB end; shift a_sh and b_sh right; cnt++.
  - Edge processing bit W-1 (cnt==W-1):
    - sum <= final r_sh including s; cout <= new carry; done <= 1; busy <= 0; go to IDLE.
- Latency: start sampled at edge k; done and sum valid after edge k+W, i.e. W cycles. Throughput is one operation per W+1 cycles minimum.
- done is high for exactly one cycle and cleared on the next edge.
- start while busy=1 is ignored; operands are not re-latched.
- start high in the cycle where done=1 is accepted; done still deasserts on that edge.
- sum/cout never show partial results; they change only on the completion edge.
- Width rules: result is modulo 2^W; cout is bit W of a+b+cin.
- W=1 degenerates to a registered full adder with 1-cycle latency.
- Input changes on a/b/cin outside the accepted-start edge have no effect.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port `sub` (1 bit), captured with the operands.
  - When sub=1, b is inverted at capture and the initial carry is forced to 1 (cin ignored), so sum = a-b mod 2^W.
  - cout=1 means no borrow (a>=b unsigned); cout=0 means borrow.
  - sub=0 gives the plain add behaviour above.
- When undefined: no `sub` port; add only.

Test Plan (W=8):
- Plain add: a=0x5A, b=0x3C, cin=0, start pulse -> done exactly 8 cycles after the start edge, sum=0x96, cout=0, busy high for those 8 cycles.
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start while busy: start a=0x01, b=0x01; 3 cycles later pulse start with a=0x80, b=0x80 -> single done, sum=0x02, cout=0, no second operation. Back-to-back: start held during the done cycle with a=0x10, b=0x20 -> second done 8 cycles later, sum=0x30.
- Reset mid-operation: start a=0x7F, b=0x01; assert rst_n=0 at cycle 4 asynchronously -> busy, done, sum and cout go to 0 immediately; no done after release; a new start completes normally.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1.
  - sub=1, a=0x00, b=0x01 -> sum=0xFF, cout=0.
  - sub=0, a=0x10, b=0x01 -> sum=0x11.
- Exhaustive W=1 build: all 8 combinations of a, b, cin -> sum=a^b^cin and cout=majority, each completing 1 cycle after start.
